mem_port_arb: RTL
=================

# mem_port_arb

Parametrised arbiter placed in front of a single-port memory wrapper (d_mem or i_mem) in the gpc tile. It lets NUM_REQ requestors (core pipeline, MMIO interface, future DMA) share one memory port. It supports fixed-priority or round-robin grant, a registered memory command, and a configurable memory read latency. Read data is routed back to the issuing requestor through a tag pipeline.

## Interface
Parameters:
- NUM_REQ, 2, number of requestors (1..8); index 0 is the core
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- RD_LAT, 1, cycles from MemRden high to MemRdData valid (1..4)
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- QClk  in  1  clock
- RstQnnnL  in  1  reset (one clock; reset is asynchronous and active-low)
- ReqValid  in  NUM_REQ  request valid, one per requestor
- ReqReady  out  NUM_REQ  request accepted this cycle
- ReqWr  in  NUM_REQ  1 = write, 0 = read
- ReqAdrs  in  NUM_REQ×ADDR_W  address per requestor
- ReqWrData  in  NUM_REQ×DATA_W  write data per requestor
- ReqByteEn  in  NUM_REQ×DATA_W/8  byte enables per requestor
- RspValid  out  NUM_REQ  read data valid for requestor i
- RspRdData  out  DATA_W  read data, shared by all requestors
- MemAdrs  out  ADDR_W  memory address
- MemWrData  out  DATA_W  memory write data
- MemByteEn  out  DATA_W/8  memory byte enables
- MemRden  out  1  memory read strobe
- MemWren  out  1  memory write strobe
- MemRdData  in  DATA_W  memory read data

## Operation
- Each cycle, at most one requestor is granted. ReqReady = one-hot grant, computed combinationally from ReqValid and the priority pointer. A transfer occurs when ReqValid[i] and ReqReady[i] are both high.
- A requestor must hold ReqValid and its payload stable until accepted. The arbiter never retracts a grant within a cycle.
- Fixed mode (RR_MODE=0): the lowest valid index wins.
- Round-robin mode (RR_MODE=1): the search starts at LastGnt+1 modulo NUM_REQ.
  - LastGnt updates only on an accepted transfer.
  - Reset value of LastGnt is NUM_REQ-1, so requestor 0 has first priority.
- Accepted request handling:
  - Address, data and byte enables are registered onto the Mem* outputs.
  - MemRden or MemWren is asserted for exactly one cycle.
  - Both strobes are never high together.
- Read tag pipeline:
  - On an accepted read, the requestor index plus a valid bit enters a shift pipeline of depth RD_LAT.
  - At the pipeline output, RspValid[idx] pulses for one cycle and RspRdData = MemRdData (combinational pass-through).
- Writes produce no response.
- With no grant in a cycle, both strobes are 0. MemAdrs, MemWrData and MemByteEn hold their last values.
- Back-to-back accepts are allowed every cycle. Throughput is one transfer per cycle and there is no stall source.
- NUM_REQ=1 degenerates to a registered pass-through. ReqReady[0] = ReqValid[0] is allowed.

## Timing
- Reset (RstQnnnL low, asynchronous):
  - MemRden=0, MemWren=0, MemAdrs=0, MemWrData=0, MemByteEn=0.
  - RspValid=0, tag pipeline cleared, LastGnt=NUM_REQ-1.
  - ReqReady is forced to 0 while in reset.
- Accept in cycle T → Mem* command valid in cycle T+1.
- Read accepted at T → MemRdData and RspValid[i] valid at T+1+RD_LAT. Total read latency is RD_LAT+1.
- Reset asserted with reads in flight: all pending tags are dropped. No RspValid pulse occurs after reset release for a request accepted before the reset.
- Requests presented in the cycle reset deasserts may be granted in that same cycle. The reset release is synchronised externally.
- Simultaneous cases:
  - A new accept and a pipeline-output response in the same cycle are independent and both proceed.
  - Two responses can never collide, because there is one issue per cycle and a fixed latency.
- ReqValid dropping without an accept is legal and has no side effect.

## Test plan
- Reset check: drive all ReqValid=1 during reset → ReqReady=0, strobes 0, RspValid=0. Release reset → requestor 0 is granted first.
- Single read, RD_LAT=2: req0 reads 0x0000_0040 at T → MemRden=1 and MemAdrs=0x40 at T+1. Memory returns 0xDEAD_BEEF at T+3 → RspValid=2'b01 and RspRdData=0xDEAD_BEEF at T+3.
- Round-robin, NUM_REQ=3, all requestors continuously valid for 6 cycles → grant sequence 0,1,2,0,1,2. With RR_MODE=0, requestor 0 is granted in all 6 cycles.
- Mixed back-to-back: req1 writes 0x1234_5678 to 0x10 with ByteEn=4'b0011, then req0 reads 0x10 on the next cycle → MemWren then MemRden on consecutive cycles. RspValid=2'b01 only, with no response for the write.
- Interleaved reads, RD_LAT=3: req0, req1, req0 issue reads on consecutive cycles → RspValid sequence 01, 10, 01 on three consecutive cycles, each paired with the matching MemRdData.
- Reset mid-flight: assert reset one cycle after a read is accepted with RD_LAT=2, then release → no RspValid pulse ever appears for that read.

Source files
------------

// File: rtl/mem_port_arb.sv
// Arbiter that lets NUM_REQ requestors share one single-port memory. Commands are registered;
// read data is steered back to the issuing requestor by a tag pipeline matched to RD_LAT.
module mem_port_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_LAT  = 1,
  parameter bit          RR_MODE = 1'b1
) (
  input  logic                          QClk,
  input  logic                          RstQnnnL,
  input  logic [NUM_REQ-1:0]            ReqValid,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic [NUM_REQ-1:0]            ReqWr,
  input  logic [NUM_REQ*ADDR_W-1:0]     ReqAdrs,
  input  logic [NUM_REQ*DATA_W-1:0]     ReqWrData,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] ReqByteEn,
  output logic [NUM_REQ-1:0]            RspValid,
  output logic [DATA_W-1:0]             RspRdData,
  output logic [ADDR_W-1:0]             MemAdrs,
  output logic [DATA_W-1:0]             MemWrData,
  output logic [DATA_W/8-1:0]           MemByteEn,
  output logic                          MemRden,
  output logic                          MemWren,
  input  logic [DATA_W-1:0]             MemRdData
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0]   last_gnt_q, last_gnt_d;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_any;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_adrs;
  logic [DATA_W-1:0] sel_wdata;
  logic [BeW-1:0]    sel_be;

  logic              mem_rden_q, mem_rden_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_adrs_q, mem_adrs_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BeW-1:0]    mem_be_q, mem_be_d;
  logic [IdxW-1:0]   cmd_idx_q, cmd_idx_d;

  logic [RD_LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][IdxW-1:0] tag_idx_q, tag_idx_d;

  // Index visited at step off of the round-robin search that begins just after base.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off + 1;
    return IdxW'(sum % NUM_REQ);
  endfunction

  // Scan from the lowest priority to the highest so the last hit is the winner.
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (RR_MODE) begin
        if (ReqValid[rr_idx(last_gnt_q, i)]) begin
          gnt_idx = rr_idx(last_gnt_q, i);
        end
      end else if (ReqValid[i]) begin
        gnt_idx = IdxW'(i);
      end
    end
  end

  assign gnt_any = RstQnnnL && (|ReqValid);

  always_comb begin
    ReqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ReqReady[i] = gnt_any && (gnt_idx == IdxW'(i));
    end
  end

  assign sel_wr    = ReqWr[gnt_idx];
  assign sel_adrs  = ReqAdrs[32'(gnt_idx) * ADDR_W +: ADDR_W];
  assign sel_wdata = ReqWrData[32'(gnt_idx) * DATA_W +: DATA_W];
  assign sel_be    = ReqByteEn[32'(gnt_idx) * BeW +: BeW];

  always_comb begin
    mem_rden_d  = gnt_any && !sel_wr;
    mem_wren_d  = gnt_any && sel_wr;
    mem_adrs_d  = mem_adrs_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    cmd_idx_d   = cmd_idx_q;
    last_gnt_d  = last_gnt_q;
    if (gnt_any) begin
      mem_adrs_d  = sel_adrs;
      mem_wdata_d = sel_wdata;
      mem_be_d    = sel_be;
      cmd_idx_d   = gnt_idx;
      if (RR_MODE) begin
        last_gnt_d = gnt_idx;
      end
    end
  end

  // The issued read strobe seeds the tag pipeline, so the last stage lines up with read data.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = mem_rden_q;
    tag_idx_d[0] = cmd_idx_q;
    for (int s = 1; s < RD_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_adrs_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      cmd_idx_q   <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      last_gnt_q  <= IdxW'(NUM_REQ - 1);
    end else begin
      mem_rden_q  <= mem_rden_d;
      mem_wren_q  <= mem_wren_d;
      mem_adrs_q  <= mem_adrs_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      cmd_idx_q   <= cmd_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  always_comb begin
    RspValid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      RspValid[i] = tag_vld_q[RD_LAT-1] && (tag_idx_q[RD_LAT-1] == IdxW'(i));
    end
  end

  assign RspRdData = MemRdData;
  assign MemRden   = mem_rden_q;
  assign MemWren   = mem_wren_q;
  assign MemAdrs   = mem_adrs_q;
  assign MemWrData = mem_wdata_q;
  assign MemByteEn = mem_be_q;

  a_strobe_excl : assert property (@(posedge QClk) disable iff (!RstQnnnL)
    !(MemRden && MemWren));
  a_grant_onehot : assert property (@(posedge QClk) disable iff (!RstQnnnL)
    $onehot0(ReqReady));

endmodule
